fp_relu_accumulator: RTL and testbench

FP_RELU_ACCUMULATOR -- requirements
Module: fp_relu_accumulator

---
 rtl/fp_relu_accumulator_pkg.sv | 14 +
 rtl/fp_relu_accumulator_f_add.sv | 54 +++++
 rtl/fp_relu_accumulator.sv | 91 +++++++++
 tb/tb_fp_relu_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_relu_accumulator_pkg.sv
// Shared definitions for the float ReLU accumulator: FSM encoding and
// IEEE-754 single-precision constants.
package fp_relu_accumulator_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] FP_ZERO  = '0;
  localparam int unsigned EXP_BIAS = 127;

endpackage

// File: rtl/fp_relu_accumulator_f_add.sv
// Combinational single-precision adder: truncating alignment, no rounding,
// no NaN/infinity/denormal handling; 32'b0 is treated as exact zero.
module f_add
  import fp_relu_accumulator_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);

  logic        w_swap;
  logic [31:0] w_l;
  logic [31:0] w_s;
  logic [7:0]  w_diff;
  logic [23:0] w_ml;
  logic [23:0] w_ms_sh;
  logic [24:0] w_sum;
  logic [23:0] w_d;
  logic [4:0]  w_lz;
  logic [22:0] w_norm;

  always_comb begin
    // Order operands by magnitude so subtraction never goes negative.
    w_swap  = B[30:0] > A[30:0];
    w_l     = w_swap ? B : A;
    w_s     = w_swap ? A : B;
    w_diff  = w_l[30:23] - w_s[30:23];
    w_ml    = {1'b1, w_l[22:0]};
    w_ms_sh = (w_diff >= 8'd25) ? '0 : ({1'b1, w_s[22:0]} >> w_diff);
    w_sum   = {1'b0, w_ml} + {1'b0, w_ms_sh};
    w_d     = w_ml - w_ms_sh;

    w_lz = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (w_d[i]) w_lz = 5'(23 - i);
    end
    w_norm = w_d[22:0] << w_lz;

    if (A == FP_ZERO)
      result = B;
    else if (B == FP_ZERO)
      result = A;
    else if (w_diff >= 8'd25)
      result = w_l;
    else if (A[31] == B[31])
      result = w_sum[24] ? {w_l[31], w_l[30:23] + 8'd1, w_sum[23:1]}
                         : {w_l[31], w_l[30:23], w_sum[22:0]};
    else if (w_d == '0)
      result = FP_ZERO;
    else
      result = {w_l[31], w_l[30:23] - {3'b000, w_lz}, w_norm};
  end

endmodule

// File: rtl/fp_relu_accumulator.sv
// Streams float product terms into a running sum, optionally ReLU-clamps the
// result and holds it until the downstream handshake.
module fp_relu_accumulator
  import fp_relu_accumulator_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             relu_en,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_acc;
  logic [31:0]      w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_ovf;
  logic             r_relu;
  logic             w_accept;
  logic             w_at_max;

  f_add u_f_add (
    .A      (r_acc),
    .B      (in_data),
    .result (w_sum)
  );

  assign w_accept  = (r_state == S_ACCUM) && in_valid;
  assign w_cnt_inc = (r_cnt == CNT_W'(MAX_TERMS)) ? r_cnt : r_cnt + 1'b1;
  assign w_at_max  = (w_cnt_inc == CNT_W'(MAX_TERMS));

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_ACCUM;
      S_ACCUM: begin
        in_ready = 1'b1;
        if (w_accept && (in_last || w_at_max)) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= FP_ZERO;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_relu  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && start) begin
        r_acc  <= FP_ZERO;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        r_relu <= relu_en;
      end
      if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
        if (w_at_max && !in_last) r_ovf <= 1'b1;
      end
    end
  end

  // Clamp applied on the output path so the raw sum stays inspectable.
  assign out_data     = (r_relu && r_acc[31]) ? FP_ZERO : r_acc;
  assign term_count   = r_cnt;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_fp_relu_accumulator.sv
// Scoreboard bench for fp_relu_accumulator with hand-computed float vectors.
module tb_fp_relu_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  term_count;
  logic        overflow_err;

  typedef struct {
    string       name;
    logic [31:0] data;
    int          cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   hs = 0;

  fp_relu_accumulator #(.MAX_TERMS(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .relu_en      (relu_en),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .term_count   (term_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      hs++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%08h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_data"}, out_data, e.data);
        chk({e.name, "_count"}, {28'd0, term_count}, 32'(e.cnt));
        chk({e.name, "_ovf"}, {31'd0, overflow_err}, {31'd0, e.ovf});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [31:0] d, input int c, input logic o);
    exp_t e;
    e.name = name; e.data = d; e.cnt = c; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic r);
    start = 1'b1; relu_en = r;
    cyc();
    start = 1'b0; relu_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    cyc();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    cyc(); cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_count", {28'd0, term_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
    rst = 1'b0;
    cyc();

    // 1.0 + 2.0 = 3.0
    do_start(1'b0);
    chk("accum_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h3F800000, 1'b0);
    push("sum3", 32'h40400000, 2, 1'b0);
    send(32'h40000000, 1'b1);
    chk("sum3_valid_next", {31'd0, out_valid}, 32'd1);
    wait_idle();

    // 1.0 + -1.0 cancels to +0
    do_start(1'b0);
    send(32'h3F800000, 1'b0);
    push("cancel", 32'h00000000, 2, 1'b0);
    send(32'hBF800000, 1'b1);
    wait_idle();

    // ReLU clamps -2.0
    do_start(1'b1);
    send(32'h3F800000, 1'b0);
    push("relu_on", 32'h00000000, 2, 1'b0);
    send(32'hC0400000, 1'b1);
    wait_idle();

    // No ReLU; a start pulse mid-accumulation must be ignored
    do_start(1'b0);
    send(32'h3F800000, 1'b0);
    start = 1'b1; relu_en = 1'b1;
    cyc();
    start = 1'b0; relu_en = 1'b0;
    push("relu_off", 32'hC0000000, 2, 1'b0);
    send(32'hC0400000, 1'b1);
    wait_idle();

    // 1.5 - 1.25 = 0.25 (left normalise), then 2^-30 aligns away entirely
    do_start(1'b0);
    send(32'h3FC00000, 1'b0);
    send(32'hBFA00000, 1'b0);
    push("norm_shift", 32'h3E800000, 3, 1'b0);
    send(32'h30800000, 1'b1);
    wait_idle();

    // Eight 1.0 terms without last: overflow, ninth beat refused
    do_start(1'b0);
    push("overflow", 32'h41000000, 8, 1'b1);
    for (int i = 0; i < 8; i++) send(32'h3F800000, 1'b0);
    in_valid = 1'b1; in_data = 32'h3F800000;
    chk("ninth_in_ready_a", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("ninth_in_ready_b", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_idle();
    chk("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    chk("count_sat", {28'd0, term_count}, 32'd8);

    // Backpressure: 2.0 + 3.0 = 5.0 held for five stalled cycles
    do_start(1'b0);
    out_ready = 1'b0;
    send(32'h40000000, 1'b0);
    push("stall", 32'h40A00000, 2, 1'b0);
    send(32'h40400000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, 32'h40A00000);
      cyc();
    end
    hs0 = hs;
    out_ready = 1'b1;
    wait_idle();
    cyc(); cyc();
    chk("stall_single_hs", 32'(hs - hs0), 32'd1);

    // Reset mid-accumulation discards the partial sum
    do_start(1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    rst = 1'b1;
    cyc();
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_count", {28'd0, term_count}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow_err}, 32'd0);
    rst = 1'b0;
    cyc(); cyc();
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    do_start(1'b0);
    push("after_rst", 32'h40000000, 1, 1'b0);
    send(32'h40000000, 1'b1);
    wait_idle();

    repeat (4) cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
